// File: rtl/adc_128s_if.sv
// Master-driven SPI lines of the ADC_128S converter model.
// MISO is a tri-state pin and is carried as a plain port on the slave.
interface adc_128s_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (output SS_n, output SCLK, output MOSI);
  modport slave  (input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/adc_128s.sv
// Behavioural 8-channel 12-bit SPI A/D converter model, 16-bit frames, SPI mode 0.
// Define ADC_128S_RAMP_EN to make each returned channel step by RAMP_STEP per completed frame.
module adc_128s #(
  parameter logic [11:0] DEFAULT_VAL = 12'h800,
  parameter logic [11:0] RAMP_STEP   = 12'h010
) (
  input  logic       clk,
  input  logic       rst_n,
  adc_128s_if.slave  spi,
  output wire        MISO
);

  logic        sclk_ff1_p0;
  logic        sclk_ff2_p0;
  logic        ss_d_p0;
  logic [15:0] rx_p0;
  logic [15:0] tx_p0;
  logic [4:0]  cnt_p0;
  logic [2:0]  prev_ch_p0;
  logic [11:0] chan_val_p0 [8];

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic rise_ok;
  logic fall_ok;
  logic frame_done;
  logic unused_ok;

  assign sclk_rise  = sclk_ff1_p0 & ~sclk_ff2_p0;
  assign sclk_fall  = ~sclk_ff1_p0 & sclk_ff2_p0;
  assign ss_fall    = ss_d_p0 & ~spi.SS_n;
  assign rise_ok    = ~spi.SS_n & ~ss_fall & sclk_rise & (cnt_p0 < 5'd16);
  // Shifting starts only after the first rise so bit 15 is seen by the master's first sample.
  assign fall_ok    = ~spi.SS_n & ~ss_fall & sclk_fall & (cnt_p0 != 5'd0) & (cnt_p0 < 5'd16);
  assign frame_done = rise_ok & (cnt_p0 == 5'd15);
  assign unused_ok  = rx_p0[15] ^ (^RAMP_STEP);

  assign MISO = spi.SS_n ? 1'bz : tx_p0[15];

  // Stage p0: SCLK oversampling, frame bit counting, RX/TX shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff1_p0 <= 1'b0;
      sclk_ff2_p0 <= 1'b0;
      ss_d_p0     <= 1'b1;
      cnt_p0      <= 5'd0;
      rx_p0       <= 16'h0000;
      tx_p0       <= 16'h0000;
      prev_ch_p0  <= 3'd0;
    end else begin
      sclk_ff1_p0 <= spi.SCLK;
      sclk_ff2_p0 <= sclk_ff1_p0;
      ss_d_p0     <= spi.SS_n;
      if (spi.SS_n) begin
        cnt_p0 <= 5'd0;
      end else if (ss_fall) begin
        tx_p0  <= {4'b0000, chan_val_p0[prev_ch_p0]};
        cnt_p0 <= 5'd0;
      end else begin
        if (rise_ok) begin
          rx_p0  <= {rx_p0[14:0], spi.MOSI};
          cnt_p0 <= cnt_p0 + 5'd1;
        end
        if (fall_ok) begin
          tx_p0 <= {tx_p0[14:0], 1'b0};
        end
        // Channel field lands in rx[13:11] once the 16th bit is shifted in.
        if (frame_done) begin
          prev_ch_p0 <= rx_p0[12:10];
        end
      end
    end
  end

`ifdef ADC_128S_RAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        chan_val_p0[i] <= DEFAULT_VAL;
      end
    end else if (frame_done) begin
      chan_val_p0[prev_ch_p0] <= chan_val_p0[prev_ch_p0] + RAMP_STEP;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        chan_val_p0[i] <= DEFAULT_VAL;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_128s.sv
// Randomized frame-level bench for adc_128s: two instances (default and 12'hFF0 preset)
// share one SPI master; a per-frame reference model predicts the returned words.
module tb_adc_128s;

`ifdef ADC_128S_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_128s_if bus ();
  wire miso_a;
  wire miso_b;
  pullup (miso_a);
  pullup (miso_b);

  adc_128s dut_a (.clk(clk), .rst_n(rst_n), .spi(bus), .MISO(miso_a));
  adc_128s #(.DEFAULT_VAL(12'hFF0)) dut_b (.clk(clk), .rst_n(rst_n), .spi(bus), .MISO(miso_b));

  int total = 0;
  int bad   = 0;

  logic [11:0] mval [2][8];
  int          mprev;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    mprev = 0;
    for (int c = 0; c < 8; c++) begin
      mval[0][c] = 12'h800;
      mval[1][c] = 12'hFF0;
    end
  endtask

  // Drives nrise SCLK cycles of cmd with SS_n low; leaves SS_n low and SCLK idle.
  task automatic run_frame(input logic [15:0] cmd, input int nrise,
                           output logic [15:0] ra, output logic [15:0] rb);
    ra = 16'h0000;
    rb = 16'h0000;
    bus.SS_n = 1'b0;
    wait_clk(3);
    for (int i = 0; i < nrise; i++) begin
      bus.MOSI = cmd[15-i];
      wait_clk(4);
      bus.SCLK = 1'b1;
      ra[15-i] = miso_a;
      rb[15-i] = miso_b;
      wait_clk(4);
      bus.SCLK = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {14'h0, miso_b, miso_a}, 16'h0003);
  endtask

  task automatic full_frame(input logic [15:0] cmd, input string tag);
    logic [15:0] ra, rb, ea, eb;
    ea = {4'b0000, mval[0][mprev]};
    eb = {4'b0000, mval[1][mprev]};
    run_frame(cmd, 16, ra, rb);
    bus.SS_n = 1'b1;
    wait_clk(3);
    chk({tag, "_a"}, ra, ea);
    chk({tag, "_b"}, rb, eb);
    chk({tag, "_hi"}, {12'h0, ra[15:12]}, 16'h0000);
    check_idle({tag, "_idle"});
    if (RAMP) begin
      mval[0][mprev] = mval[0][mprev] + 12'h010;
      mval[1][mprev] = mval[1][mprev] + 12'h010;
    end
    mprev = int'(cmd[13:11]);
  endtask

  task automatic abort_frame(input logic [15:0] cmd, input int n, input string tag);
    logic [15:0] ra, rb, ea;
    ea = {4'b0000, mval[0][mprev]};
    run_frame(cmd, n, ra, rb);
    bus.SS_n = 1'b1;
    wait_clk(3);
    chk({tag, "_part"}, ra >> (16 - n), ea >> (16 - n));
    check_idle({tag, "_idle"});
  endtask

  initial begin
    logic [15:0] ra, rb, cmd;
    rst_n    = 1'b0;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    model_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check_idle("rst_idle");

    // Channel-3 sequence: first frame returns channel 0, then channel 3 (ramping if enabled)
    full_frame(16'h1800, "ch3_f1");
    full_frame(16'h1800, "ch3_f2");
    full_frame(16'h1800, "ch3_f3");
    full_frame(16'h1800, "ch3_f4");

    // Aborted frame leaves addressing and values untouched
    abort_frame(16'h2800, 8, "abort8");
    full_frame(16'h0000, "after_abort");

    // SCLK activity while deselected is ignored
    repeat (5) begin
      bus.SCLK = 1'b1;
      wait_clk(4);
      bus.SCLK = 1'b0;
      wait_clk(4);
    end
    check_idle("ss_hi_sclk_idle");
    full_frame(16'h3000, "after_ss_hi_sclk");

    // Reset in the middle of a frame
    run_frame(16'h3800, 10, ra, rb);
    rst_n    = 1'b0;
    wait_clk(2);
    bus.SS_n = 1'b1;
    model_reset();
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(3);
    check_idle("midrst_idle");
    full_frame(16'h1000, "after_midrst");
    full_frame(16'h1000, "after_midrst2");

    for (int k = 0; k < 24; k++) begin
      cmd = 16'($urandom);
      if ($urandom_range(0, 4) == 0)
        abort_frame(cmd, int'($urandom_range(1, 15)), $sformatf("rnd%0d_abort", k));
      else
        full_frame(cmd, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
